// File: rtl/mips_decode_exec_pkg.sv
// ============================================================================
// Module   : mips_decode_exec_pkg
// Brief    : Shared constants for the MIPS decode/execute slice: control-word
//            layout, ALU op encodings and opcode/funct values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_decode_exec_pkg;

  localparam int CNTRL_REG_SIZE = 16;

  // Control word bit positions, MSB to LSB
  localparam int CB_REG_WRITE   = 15;
  localparam int CB_MEM_READ    = 14;
  localparam int CB_MEM_WRITE   = 13;
  localparam int CB_BRANCH      = 12;
  localparam int CB_BRANCH_NE   = 11;
  localparam int CB_JUMP        = 10;
  localparam int CB_JUMP_REG    = 9;
  localparam int CB_LINK        = 8;
  localparam int CB_ALU_SRC_IMM = 7;
  localparam int CB_IMM_ZEXT    = 6;
  localparam int CB_DEST_RT     = 5;
  localparam int CB_SHIFT_SHAMT = 4;

  localparam logic [CNTRL_REG_SIZE-1:0] F_REG_WRITE   = 16'h8000;
  localparam logic [CNTRL_REG_SIZE-1:0] F_MEM_READ    = 16'h4000;
  localparam logic [CNTRL_REG_SIZE-1:0] F_MEM_WRITE   = 16'h2000;
  localparam logic [CNTRL_REG_SIZE-1:0] F_BRANCH      = 16'h1000;
  localparam logic [CNTRL_REG_SIZE-1:0] F_BRANCH_NE   = 16'h0800;
  localparam logic [CNTRL_REG_SIZE-1:0] F_JUMP        = 16'h0400;
  localparam logic [CNTRL_REG_SIZE-1:0] F_JUMP_REG    = 16'h0200;
  localparam logic [CNTRL_REG_SIZE-1:0] F_LINK        = 16'h0100;
  localparam logic [CNTRL_REG_SIZE-1:0] F_ALU_SRC_IMM = 16'h0080;
  localparam logic [CNTRL_REG_SIZE-1:0] F_IMM_ZEXT    = 16'h0040;
  localparam logic [CNTRL_REG_SIZE-1:0] F_DEST_RT     = 16'h0020;
  localparam logic [CNTRL_REG_SIZE-1:0] F_SHIFT_SHAMT = 16'h0010;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic logic [CNTRL_REG_SIZE-1:0] cw(input logic [CNTRL_REG_SIZE-1:0] flags,
                                                   input alu_op_e op);
    return flags | {{(CNTRL_REG_SIZE-4){1'b0}}, op};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_decode_exec_regfile.sv
// ============================================================================
// Module   : mips_regfile
// Brief    : 32x32 register file, two combinational read ports, one write
//            port, $0 hard-wired to zero. Macro REGFILE_BYPASS_EN forwards
//            same-cycle write data to matching read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] r_regs [32];
  logic [4:0]  w_raddr [2];
  logic [31:0] w_rdata [2];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign w_raddr[0] = raddr_a;
  assign w_raddr[1] = raddr_b;

  for (genvar p = 0; p < 2; p++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
    logic w_hit;
    assign w_hit = we && !reset && (waddr != 5'd0) && (waddr == w_raddr[p]);
    assign w_rdata[p] = (w_raddr[p] == 5'd0) ? 32'd0 :
                        w_hit ? wdata : r_regs[w_raddr[p]];
`else
    assign w_rdata[p] = (w_raddr[p] == 5'd0) ? 32'd0 : r_regs[w_raddr[p]];
`endif
  end

  assign rdata_a = w_rdata[0];
  assign rdata_b = w_rdata[1];

endmodule

`default_nettype wire

// File: rtl/mips_decode_exec.sv
// ============================================================================
// Module   : mips_decode_exec
// Brief    : Decode, register-file read and execute slice of the in-order MIPS
//            core. Decode registers at edge N, execute at edge N+1.
//            Optional macro: REGFILE_BYPASS_EN (write-to-read bypass).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_decode_exec
  import mips_decode_exec_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               insn,
  input  logic [31:0]               pc_in,
  input  logic                      valid_insn,
  input  logic                      wb_we,
  input  logic [4:0]                wb_addr,
  input  logic [31:0]               wb_data,
  output logic [4:0]                rs_idx,
  output logic [4:0]                rt_idx,
  output logic [4:0]                rd_idx,
  output logic [CNTRL_REG_SIZE-1:0] control,
  output logic                      illegal_insn,
  output logic [31:0]               rs_data,
  output logic [31:0]               rt_data,
  output logic [31:0]               alu_out,
  output logic                      branch_taken,
  output logic [31:0]               branch_target
);

  logic [5:0]                w_opcode;
  logic [5:0]                w_funct;
  logic [CNTRL_REG_SIZE-1:0] w_ctrl;
  logic                      w_illegal;
  logic                      w_accept;
  logic [4:0]                w_dest;

  logic [31:0]               r_pc;
  logic [25:0]               r_field;

  assign w_opcode = insn[31:26];
  assign w_funct  = insn[5:0];

  always_comb begin
    w_ctrl    = '0;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_SLL:  w_ctrl = cw(F_REG_WRITE | F_SHIFT_SHAMT, ALU_SLL);
          FN_SRL:  w_ctrl = cw(F_REG_WRITE | F_SHIFT_SHAMT, ALU_SRL);
          FN_SRA:  w_ctrl = cw(F_REG_WRITE | F_SHIFT_SHAMT, ALU_SRA);
          FN_JR:   w_ctrl = cw(F_JUMP | F_JUMP_REG, ALU_ADD);
          FN_ADDU: w_ctrl = cw(F_REG_WRITE, ALU_ADD);
          FN_SUBU: w_ctrl = cw(F_REG_WRITE, ALU_SUB);
          FN_AND:  w_ctrl = cw(F_REG_WRITE, ALU_AND);
          FN_OR:   w_ctrl = cw(F_REG_WRITE, ALU_OR);
          FN_XOR:  w_ctrl = cw(F_REG_WRITE, ALU_XOR);
          FN_NOR:  w_ctrl = cw(F_REG_WRITE, ALU_NOR);
          FN_SLT:  w_ctrl = cw(F_REG_WRITE, ALU_SLT);
          FN_SLTU: w_ctrl = cw(F_REG_WRITE, ALU_SLTU);
          default: w_illegal = 1'b1;
        endcase
      end
      OP_ADDIU: w_ctrl = cw(F_REG_WRITE | F_ALU_SRC_IMM | F_DEST_RT, ALU_ADD);
      OP_SLTI:  w_ctrl = cw(F_REG_WRITE | F_ALU_SRC_IMM | F_DEST_RT, ALU_SLT);
      OP_SLTIU: w_ctrl = cw(F_REG_WRITE | F_ALU_SRC_IMM | F_DEST_RT, ALU_SLTU);
      OP_ANDI:  w_ctrl = cw(F_REG_WRITE | F_ALU_SRC_IMM | F_IMM_ZEXT | F_DEST_RT, ALU_AND);
      OP_ORI:   w_ctrl = cw(F_REG_WRITE | F_ALU_SRC_IMM | F_IMM_ZEXT | F_DEST_RT, ALU_OR);
      OP_XORI:  w_ctrl = cw(F_REG_WRITE | F_ALU_SRC_IMM | F_IMM_ZEXT | F_DEST_RT, ALU_XOR);
      OP_LUI:   w_ctrl = cw(F_REG_WRITE | F_ALU_SRC_IMM | F_DEST_RT, ALU_LUI);
      OP_LW:    w_ctrl = cw(F_REG_WRITE | F_MEM_READ | F_ALU_SRC_IMM | F_DEST_RT, ALU_ADD);
      OP_SW:    w_ctrl = cw(F_MEM_WRITE | F_ALU_SRC_IMM, ALU_ADD);
      OP_BEQ:   w_ctrl = cw(F_BRANCH, ALU_SUB);
      OP_BNE:   w_ctrl = cw(F_BRANCH | F_BRANCH_NE, ALU_SUB);
      OP_J:     w_ctrl = cw(F_JUMP, ALU_ADD);
      OP_JAL:   w_ctrl = cw(F_JUMP | F_LINK | F_REG_WRITE, ALU_ADD);
      default:  w_illegal = 1'b1;
    endcase
    // Bubbles decode as an all-zero NOP regardless of the instruction bits
    if (!valid_insn) begin
      w_ctrl    = '0;
      w_illegal = 1'b0;
    end
  end

  assign w_accept = valid_insn && !w_illegal;
  assign w_dest   = w_ctrl[CB_DEST_RT] ? insn[20:16] :
                    w_ctrl[CB_LINK]    ? 5'd31       : insn[15:11];

  always_ff @(posedge clock) begin
    if (reset) begin
      rs_idx       <= '0;
      rt_idx       <= '0;
      rd_idx       <= '0;
      control      <= '0;
      illegal_insn <= 1'b0;
      r_pc         <= '0;
      r_field      <= '0;
    end else begin
      rs_idx       <= w_accept ? insn[25:21] : 5'd0;
      rt_idx       <= w_accept ? insn[20:16] : 5'd0;
      rd_idx       <= w_accept ? w_dest      : 5'd0;
      control      <= w_ctrl;
      illegal_insn <= w_illegal;
      r_pc         <= w_accept ? pc_in       : 32'd0;
      r_field      <= w_accept ? insn[25:0]  : 26'd0;
    end
  end

  mips_regfile u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_idx),
    .raddr_b (rt_idx),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

  logic [15:0] w_imm16;
  logic [4:0]  w_shamt;
  logic [31:0] w_imm_ext;
  logic [31:0] w_opb;
  logic [31:0] w_pc4;
  alu_op_e     w_op;
  logic [31:0] w_alu;
  logic        w_taken;
  logic [31:0] w_target;

  assign w_imm16   = r_field[15:0];
  assign w_shamt   = r_field[10:6];
  assign w_imm_ext = control[CB_IMM_ZEXT] ? {16'd0, w_imm16} : {{16{w_imm16[15]}}, w_imm16};
  assign w_opb     = control[CB_ALU_SRC_IMM] ? w_imm_ext : rt_data;
  assign w_pc4     = r_pc + 32'd4;
  assign w_op      = alu_op_e'(control[3:0]);

  always_comb begin
    w_alu = '0;
    case (w_op)
      ALU_ADD:  w_alu = rs_data + w_opb;
      ALU_SUB:  w_alu = rs_data - w_opb;
      ALU_AND:  w_alu = rs_data & w_opb;
      ALU_OR:   w_alu = rs_data | w_opb;
      ALU_XOR:  w_alu = rs_data ^ w_opb;
      ALU_NOR:  w_alu = ~(rs_data | w_opb);
      ALU_SLT:  w_alu = {31'd0, $signed(rs_data) < $signed(w_opb)};
      ALU_SLTU: w_alu = {31'd0, rs_data < w_opb};
      ALU_SLL:  w_alu = rt_data << w_shamt;
      ALU_SRL:  w_alu = rt_data >> w_shamt;
      ALU_SRA:  w_alu = $signed(rt_data) >>> w_shamt;
      ALU_LUI:  w_alu = {w_imm16, 16'd0};
      default:  w_alu = '0;
    endcase
    // JAL returns the link address instead of an ALU value
    if (control[CB_LINK]) w_alu = r_pc + 32'd8;
  end

  assign w_taken = control[CB_JUMP] |
                   (control[CB_BRANCH] & (control[CB_BRANCH_NE] ? (rs_data != rt_data)
                                                                : (rs_data == rt_data)));

  always_comb begin
    w_target = '0;
    if (w_taken) begin
      if (control[CB_JUMP_REG])  w_target = rs_data;
      else if (control[CB_JUMP]) w_target = {w_pc4[31:28], r_field, 2'b00};
      else                       w_target = w_pc4 + {w_imm_ext[29:0], 2'b00};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_out       <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      alu_out       <= w_alu;
      branch_taken  <= w_taken;
      branch_target <= w_target;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_decode_exec.sv
// ============================================================================
// Module   : tb_mips_decode_exec
// Brief    : Self-checking bench for mips_decode_exec with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_decode_exec;
  import mips_decode_exec_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [31:0]               insn = '0;
  logic [31:0]               pc_in = '0;
  logic                      valid_insn = 1'b0;
  logic                      wb_we = 1'b0;
  logic [4:0]                wb_addr = '0;
  logic [31:0]               wb_data = '0;
  logic [4:0]                rs_idx, rt_idx, rd_idx;
  logic [CNTRL_REG_SIZE-1:0] control;
  logic                      illegal_insn;
  logic [31:0]               rs_data, rt_data, alu_out, branch_target;
  logic                      branch_taken;

  int n_cmp = 0;
  int n_err = 0;

  string       q_tag [$];
  logic        q_ca  [$];
  logic        q_cb  [$];
  logic [31:0] q_alu [$];
  logic        q_tak [$];
  logic [31:0] q_tgt [$];

  always #5 clock = ~clock;

  mips_decode_exec dut (
    .clock         (clock),
    .reset         (reset),
    .insn          (insn),
    .pc_in         (pc_in),
    .valid_insn    (valid_insn),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .rs_idx        (rs_idx),
    .rt_idx        (rt_idx),
    .rd_idx        (rd_idx),
    .control       (control),
    .illegal_insn  (illegal_insn),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .alu_out       (alu_out),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive one slot, advance one edge, then retire the slot issued one edge earlier.
  task automatic issue(input logic v, input logic [31:0] i, input logic [31:0] pc,
                       input string tag, input logic ca, input logic [31:0] ea,
                       input logic cb, input logic et, input logic [31:0] eg);
    string       t;
    logic        a, b, k;
    logic [31:0] x, g;
    valid_insn = v;
    insn       = i;
    pc_in      = pc;
    q_tag.push_back(tag); q_ca.push_back(ca); q_cb.push_back(cb);
    q_alu.push_back(ea);  q_tak.push_back(et); q_tgt.push_back(eg);
    @(posedge clock);
    #1;
    if (q_tag.size() > 1) begin
      t = q_tag.pop_front(); a = q_ca.pop_front(); b = q_cb.pop_front();
      x = q_alu.pop_front(); k = q_tak.pop_front(); g = q_tgt.pop_front();
      if (a) chk({t, "_alu"}, alu_out, x);
      if (b) begin
        chk({t, "_taken"}, {31'd0, branch_taken}, {31'd0, k});
        chk({t, "_target"}, branch_target, g);
      end
    end
  endtask

  task automatic bubble();
    issue(1'b0, 32'd0, 32'd0, "bubble", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we   = 1'b1;
    wb_addr = a;
    wb_data = d;
    bubble();
    wb_we   = 1'b0;
  endtask

  localparam logic [31:0] PC_BR = 32'h8002_0000;

  logic [31:0] exp_byp;

  initial begin
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'd9;
`else
    exp_byp = 32'd3;
`endif
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_rs_idx", {27'd0, rs_idx}, 32'd0);
    chk("rst_rt_idx", {27'd0, rt_idx}, 32'd0);
    chk("rst_rd_idx", {27'd0, rd_idx}, 32'd0);
    chk("rst_control", {16'd0, control}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_insn}, 32'd0);
    chk("rst_alu", alu_out, 32'd0);
    chk("rst_taken", {31'd0, branch_taken}, 32'd0);
    chk("rst_target", branch_target, 32'd0);
    reset = 1'b0;

    issue(1'b1, enc_r(5'd5, 5'd0, 5'd7, 5'd0, 6'h25), 32'd0, "or_r5", 1'b1, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("r5_idx", {27'd0, rs_idx}, 32'd5);
    chk("r5_data", rs_data, 32'd0);

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    issue(1'b1, 32'h0022_1821, 32'd0, "addu", 1'b1, 32'd12, 1'b1, 1'b0, 32'd0);
    chk("addu_rd", {27'd0, rd_idx}, 32'd3);
    chk("addu_rw", {31'd0, control[15]}, 32'd1);
    chk("addu_rs", rs_data, 32'd5);
    chk("addu_rt", rt_data, 32'd7);

    // Back-to-back immediates exercise one-per-cycle throughput
    issue(1'b1, enc_i(6'h09, 5'd1, 5'd4, 16'hFFFF), 32'd0, "addiu", 1'b1, 32'd4, 1'b1, 1'b0, 32'd0);
    chk("addiu_rd", {27'd0, rd_idx}, 32'd4);
    issue(1'b1, enc_i(6'h0D, 5'd0, 5'd4, 16'h8000), 32'd0, "ori", 1'b1, 32'h0000_8000, 1'b1, 1'b0, 32'd0);
    issue(1'b1, enc_i(6'h0F, 5'd0, 5'd4, 16'h1234), 32'd0, "lui", 1'b1, 32'h1234_0000, 1'b1, 1'b0, 32'd0);
    issue(1'b1, enc_r(5'd0, 5'd1, 5'd12, 5'd0, 6'h23), 32'd0, "subu", 1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0, 32'd0);
    bubble();

    wb_write(5'd10, 32'h8000_0010);
    issue(1'b1, enc_r(5'd0, 5'd10, 5'd9, 5'd4, 6'h03), 32'd0, "sra", 1'b1, 32'hF800_0001, 1'b0, 1'b0, 32'd0);
    issue(1'b1, enc_r(5'd0, 5'd10, 5'd9, 5'd4, 6'h02), 32'd0, "srl", 1'b1, 32'h0800_0001, 1'b0, 1'b0, 32'd0);
    issue(1'b1, enc_r(5'd10, 5'd1, 5'd11, 5'd0, 6'h2A), 32'd0, "slt", 1'b1, 32'd1, 1'b0, 1'b0, 32'd0);
    issue(1'b1, enc_r(5'd10, 5'd1, 5'd11, 5'd0, 6'h2B), 32'd0, "sltu", 1'b1, 32'd0, 1'b0, 1'b0, 32'd0);

    wb_write(5'd2, 32'd5);
    issue(1'b1, enc_i(6'h04, 5'd1, 5'd2, 16'd3), PC_BR, "beq_eq", 1'b0, 32'd0, 1'b1, 1'b1, 32'h8002_0010);
    bubble();
    wb_write(5'd2, 32'd7);
    issue(1'b1, enc_i(6'h04, 5'd1, 5'd2, 16'd3), PC_BR, "beq_ne", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    issue(1'b1, enc_i(6'h05, 5'd1, 5'd2, 16'd3), PC_BR, "bne", 1'b0, 32'd0, 1'b1, 1'b1, 32'h8002_0010);
    issue(1'b1, {6'h03, 26'h004_0000}, PC_BR, "jal", 1'b1, 32'h8002_0008, 1'b1, 1'b1, 32'h8010_0000);
    chk("jal_rd", {27'd0, rd_idx}, 32'd31);
    issue(1'b1, enc_r(5'd1, 5'd0, 5'd0, 5'd0, 6'h08), 32'd0, "jr", 1'b0, 32'd0, 1'b1, 1'b1, 32'd5);

    issue(1'b0, 32'h0022_1821, 32'd0, "inval", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("inval_ctrl", {16'd0, control}, 32'd0);
    chk("inval_rd", {27'd0, rd_idx}, 32'd0);
    chk("inval_ill", {31'd0, illegal_insn}, 32'd0);
    issue(1'b1, 32'hFC00_0000, 32'd0, "illeg", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("illeg_flag", {31'd0, illegal_insn}, 32'd1);
    chk("illeg_ctrl", {16'd0, control}, 32'd0);
    issue(1'b1, 32'd0, 32'd0, "nop", 1'b1, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("nop_ill", {31'd0, illegal_insn}, 32'd0);
    bubble();

    wb_write(5'd6, 32'd3);
    issue(1'b1, enc_r(5'd6, 5'd0, 5'd7, 5'd0, 6'h21), 32'd0, "byp", 1'b1, exp_byp, 1'b0, 1'b0, 32'd0);
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'd9;
    #1;
    chk("byp_read", rs_data, exp_byp);
    bubble();
    wb_we = 1'b0;
    issue(1'b1, enc_r(5'd6, 5'd0, 5'd7, 5'd0, 6'h21), 32'd0, "after_wr", 1'b1, 32'd9, 1'b0, 1'b0, 32'd0);
    chk("after_wr_read", rs_data, 32'd9);

    issue(1'b1, enc_r(5'd0, 5'd0, 5'd8, 5'd0, 6'h25), 32'd0, "r0_a", 1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    #1;
    chk("r0_same_cycle", rs_data, 32'd0);
    bubble();
    wb_we = 1'b0;
    issue(1'b1, enc_r(5'd0, 5'd0, 5'd8, 5'd0, 6'h25), 32'd0, "r0_b", 1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("r0_after", rs_data, 32'd0);
    bubble();
    bubble();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
